// File: rtl/rx_cmd_pkg.sv
// Shared definitions for the receive-side command controller.
// Command codes, FSM state encoding and fixed ALU operand addresses.
package rx_cmd_pkg;

  localparam logic [7:0] CMD_WR     = 8'hAA;
  localparam logic [7:0] CMD_RD     = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP = 8'hCC;
  localparam logic [7:0] CMD_ALU    = 8'hDD;

  localparam int unsigned OP_A_ADDR = 0;
  localparam int unsigned OP_B_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
    OP_A, OP_B, ALU_FN, ALU_WAIT, TX_LO, TX_HI
  } state_e;

  // States that are waiting on the next byte of a partially received frame.
  function automatic logic is_partial(state_e s);
    return s inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FN};
  endfunction

endpackage

// File: rtl/rx_cmd_timer.sv
// Inactivity counter for partial frames; expires after TMO_CYC idle cycles.
// Only instantiated when RX_CMD_TIMEOUT_EN is defined.
module rx_cmd_timer #(
  parameter int unsigned TMO_CYC = 1023
) (
  input  logic clck,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clck or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run) cnt <= cnt + 1'b1;
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign expired = run && !clr && (cnt == CW'(TMO_CYC - 1));

endmodule

// File: rtl/rx_cmd_ctrl.sv
// Byte-stream command decoder driving a register file, an ALU and a transmitter.
// Optional partial-frame timeout is enabled with `define RX_CMD_TIMEOUT_EN.
module rx_cmd_ctrl
  import rx_cmd_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TMO_CYC = 1023
) (
  input  logic                clck,
  input  logic                rst,
  input  logic [DATA_W-1:0]   rx_p_data,
  input  logic                rx_d_valid,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic                rd_data_valid,
  input  logic [2*DATA_W-1:0] alu_out,
  input  logic                alu_out_valid,
  input  logic                tx_busy,
  output logic [ADDR_W-1:0]   addr,
  output logic                wr_en,
  output logic                rd_en,
  output logic [DATA_W-1:0]   wr_data,
  output logic                alu_en,
  output logic [3:0]          alu_fun,
  output logic                clk_gate_en,
  output logic [DATA_W-1:0]   tx_p_data,
  output logic                tx_d_valid,
  output logic                cmd_err
);

  state_e              state_q, state_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic                is_alu_q, is_alu_d, busy_q;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wr_data_d, tx_p_data_d;
  logic [3:0]          alu_fun_d;
  logic                wr_en_d, rd_en_d, alu_en_d, tx_d_valid_d, cmd_err_d;

`ifdef RX_CMD_TIMEOUT_EN
  logic tmo_expired;

  rx_cmd_timer #(.TMO_CYC(TMO_CYC)) u_timer (
    .clck    (clck),
    .rst     (rst),
    .clr     (rx_d_valid || !is_partial(state_q)),
    .run     (is_partial(state_q)),
    .expired (tmo_expired)
  );
`endif

  always_comb begin
    state_d      = state_q;
    res_d        = res_q;
    is_alu_d     = is_alu_q;
    addr_d       = addr;
    wr_data_d    = wr_data;
    alu_fun_d    = alu_fun;
    tx_p_data_d  = tx_p_data;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    alu_en_d     = 1'b0;
    tx_d_valid_d = 1'b0;
    cmd_err_d    = 1'b0;
    case (state_q)
      IDLE: if (rx_d_valid) begin
        if      (rx_p_data == DATA_W'(CMD_WR))     state_d = WR_ADDR;
        else if (rx_p_data == DATA_W'(CMD_RD))     state_d = RD_ADDR;
        else if (rx_p_data == DATA_W'(CMD_ALU_OP)) state_d = OP_A;
        else if (rx_p_data == DATA_W'(CMD_ALU))    state_d = ALU_FN;
        else                                       cmd_err_d = 1'b1;
      end
      WR_ADDR: if (rx_d_valid) begin
        addr_d  = rx_p_data[ADDR_W-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (rx_d_valid) begin
        wr_data_d = rx_p_data;
        wr_en_d   = 1'b1;
        state_d   = IDLE;
      end
      RD_ADDR: if (rx_d_valid) begin
        addr_d  = rx_p_data[ADDR_W-1:0];
        rd_en_d = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        cmd_err_d = rx_d_valid;
        if (rd_data_valid) begin
          tx_p_data_d = rd_data;
          res_d       = {{DATA_W{1'b0}}, rd_data};
          is_alu_d    = 1'b0;
          state_d     = TX_LO;
        end
      end
      OP_A: if (rx_d_valid) begin
        addr_d    = ADDR_W'(OP_A_ADDR);
        wr_data_d = rx_p_data;
        wr_en_d   = 1'b1;
        state_d   = OP_B;
      end
      OP_B: if (rx_d_valid) begin
        addr_d    = ADDR_W'(OP_B_ADDR);
        wr_data_d = rx_p_data;
        wr_en_d   = 1'b1;
        state_d   = ALU_FN;
      end
      ALU_FN: if (rx_d_valid) begin
        alu_fun_d = rx_p_data[3:0];
        alu_en_d  = 1'b1;
        state_d   = ALU_WAIT;
      end
      ALU_WAIT: begin
        cmd_err_d = rx_d_valid;
        if (alu_out_valid) begin
          res_d    = alu_out;
          is_alu_d = 1'b1;
          state_d  = TX_LO;
        end
      end
      TX_LO: begin
        cmd_err_d = rx_d_valid;
        if (!tx_busy) begin
          tx_p_data_d  = res_q[DATA_W-1:0];
          tx_d_valid_d = 1'b1;
          state_d      = is_alu_q ? TX_HI : IDLE;
        end
      end
      TX_HI: begin
        cmd_err_d = rx_d_valid;
        // Require a quiet cycle after busy drops so the high byte never races
        // the transmitter's release edge.
        if (!tx_busy && !busy_q) begin
          tx_p_data_d  = res_q[2*DATA_W-1:DATA_W];
          tx_d_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef RX_CMD_TIMEOUT_EN
    if (tmo_expired) begin
      state_d   = IDLE;
      cmd_err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      res_q       <= '0;
      is_alu_q    <= 1'b0;
      busy_q      <= 1'b0;
      addr        <= '0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      wr_data     <= '0;
      alu_en      <= 1'b0;
      alu_fun     <= '0;
      clk_gate_en <= 1'b0;
      tx_p_data   <= '0;
      tx_d_valid  <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      is_alu_q    <= is_alu_d;
      busy_q      <= tx_busy;
      addr        <= addr_d;
      wr_en       <= wr_en_d;
      rd_en       <= rd_en_d;
      wr_data     <= wr_data_d;
      alu_en      <= alu_en_d;
      alu_fun     <= alu_fun_d;
      clk_gate_en <= state_d inside {OP_A, OP_B, ALU_FN, ALU_WAIT};
      tx_p_data   <= tx_p_data_d;
      tx_d_valid  <= tx_d_valid_d;
      cmd_err     <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Self-checking bench for rx_cmd_ctrl: directed frames plus randomized frames
// checked against a transaction-level event model.
module tb_rx_cmd_ctrl;

  logic        clck = 1'b0;
  logic        rst;
  logic [7:0]  rx_p_data, rd_data;
  logic        rx_d_valid, rd_data_valid, alu_out_valid, tx_busy;
  logic [15:0] alu_out;
  logic [3:0]  addr, alu_fun;
  logic        wr_en, rd_en, alu_en, clk_gate_en, tx_d_valid, cmd_err;
  logic [7:0]  wr_data, tx_p_data;

  int total = 0;
  int bad   = 0;

  typedef struct { int k; int a; int d; } ev_t;  // k: 0 wr, 1 rd, 2 alu, 3 tx, 4 err
  ev_t obs[$];
  ev_t exp_q[$];
  int  n_wr = 0, n_rd = 0, n_alu = 0, n_tx = 0, n_err = 0;

  wire [30:0] out_vec = {addr, wr_en, rd_en, wr_data, alu_en, alu_fun, clk_gate_en,
                         tx_p_data, tx_d_valid, cmd_err};

  always #5 clck = ~clck;

  rx_cmd_ctrl #(.DATA_W(8), .ADDR_W(4), .TMO_CYC(16)) dut (
    .clck(clck), .rst(rst),
    .rx_p_data(rx_p_data), .rx_d_valid(rx_d_valid),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .tx_busy(tx_busy),
    .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data),
    .alu_en(alu_en), .alu_fun(alu_fun), .clk_gate_en(clk_gate_en),
    .tx_p_data(tx_p_data), .tx_d_valid(tx_d_valid), .cmd_err(cmd_err)
  );

  always @(negedge clck) if (rst) begin
    if (wr_en)      begin obs.push_back('{0, int'(addr), int'(wr_data)});   n_wr++;  end
    if (rd_en)      begin obs.push_back('{1, int'(addr), 0});               n_rd++;  end
    if (alu_en)     begin obs.push_back('{2, 0, int'(alu_fun)});            n_alu++; end
    if (tx_d_valid) begin obs.push_back('{3, 0, int'(tx_p_data)});          n_tx++;  end
    if (cmd_err)    begin obs.push_back('{4, 0, 0});                        n_err++; end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clck); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_p_data = b; rx_d_valid = 1'b1;
    tick();
    rx_d_valid = 1'b0; rx_p_data = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    total++;
    if (out_vec !== '0) begin bad++; $display("FAIL reset_hold: outputs=%h want 0", out_vec); end
    rst = 1'b1;
    tick();
    total++;
    if (out_vec !== '0) begin bad++; $display("FAIL reset_release: outputs=%h want 0", out_vec); end
  endtask

  task automatic test_write();
    send_byte(8'hAA);
    send_byte(8'h05);
    total++;
    if (wr_en !== 1'b0) begin bad++; $display("FAIL wr_early: wr_en=%b want 0", wr_en); end
    send_byte(8'h3C);
    total++;
    if ({wr_en, addr, wr_data} !== {1'b1, 4'h5, 8'h3C}) begin
      bad++; $display("FAIL wr_strobe: wr_en=%b addr=%h data=%h want 1/5/3c", wr_en, addr, wr_data);
    end
    tick();
    total++;
    if (wr_en !== 1'b0) begin bad++; $display("FAIL wr_one_cycle: wr_en=%b want 0", wr_en); end
  endtask

  task automatic test_read();
    int n0, k;
    n0 = n_tx;
    send_byte(8'hBB);
    send_byte(8'h07);
    total++;
    if ({rd_en, addr} !== {1'b1, 4'h7}) begin
      bad++; $display("FAIL rd_strobe: rd_en=%b addr=%h want 1/7", rd_en, addr);
    end
    tick();
    total++;
    if (rd_en !== 1'b0) begin bad++; $display("FAIL rd_one_cycle: rd_en=%b want 0", rd_en); end
    rd_data = 8'h5A; rd_data_valid = 1'b1;
    tick();
    rd_data_valid = 1'b0; rd_data = 8'h00;
    k = 0;
    while (!tx_d_valid && k < 10) begin tick(); k++; end
    total++;
    if ({tx_d_valid, tx_p_data} !== {1'b1, 8'h5A}) begin
      bad++; $display("FAIL rd_tx: valid=%b data=%h want 1/5a", tx_d_valid, tx_p_data);
    end
    repeat (5) tick();
    total++;
    if (n_tx - n0 !== 1) begin bad++; $display("FAIL rd_tx_count: got %0d want 1", n_tx - n0); end
  endtask

  task automatic test_alu();
    int n0, k;
    tx_busy = 1'b1;
    send_byte(8'hCC);
    total++;
    if (clk_gate_en !== 1'b1) begin bad++; $display("FAIL gate_on: clk_gate_en=%b want 1", clk_gate_en); end
    send_byte(8'h10);
    total++;
    if ({wr_en, addr, wr_data} !== {1'b1, 4'h0, 8'h10}) begin
      bad++; $display("FAIL op_a: wr_en=%b addr=%h data=%h want 1/0/10", wr_en, addr, wr_data);
    end
    send_byte(8'h20);
    total++;
    if ({wr_en, addr, wr_data} !== {1'b1, 4'h1, 8'h20}) begin
      bad++; $display("FAIL op_b: wr_en=%b addr=%h data=%h want 1/1/20", wr_en, addr, wr_data);
    end
    send_byte(8'h01);
    total++;
    if ({alu_en, alu_fun, clk_gate_en} !== {1'b1, 4'h1, 1'b1}) begin
      bad++; $display("FAIL alu_en: en=%b fun=%h gate=%b want 1/1/1", alu_en, alu_fun, clk_gate_en);
    end
    alu_out = 16'h0030; alu_out_valid = 1'b1;
    tick();
    alu_out_valid = 1'b0; alu_out = 16'hFFFF;
    total++;
    if (clk_gate_en !== 1'b0) begin bad++; $display("FAIL gate_off: clk_gate_en=%b want 0", clk_gate_en); end
    n0 = n_tx;
    repeat (18) tick();
    total++;
    if (n_tx !== n0) begin bad++; $display("FAIL busy_lo: sent %0d while busy want 0", n_tx - n0); end
    tx_busy = 1'b0;
    k = 0;
    while (!tx_d_valid && k < 10) begin tick(); k++; end
    total++;
    if ({tx_d_valid, tx_p_data} !== {1'b1, 8'h30}) begin
      bad++; $display("FAIL alu_tx_lo: valid=%b data=%h want 1/30", tx_d_valid, tx_p_data);
    end
    tx_busy = 1'b1;
    repeat (20) tick();
    total++;
    if (n_tx !== n0 + 1) begin bad++; $display("FAIL busy_hi: sent %0d want 1", n_tx - n0); end
    tx_busy = 1'b0;
    k = 0;
    while (!tx_d_valid && k < 10) begin tick(); k++; end
    total++;
    if ({tx_d_valid, tx_p_data} !== {1'b1, 8'h00}) begin
      bad++; $display("FAIL alu_tx_hi: valid=%b data=%h want 1/00", tx_d_valid, tx_p_data);
    end
    tick();
  endtask

  task automatic test_bad_cmd();
    send_byte(8'h55);
    total++;
    if ({cmd_err, wr_en, rd_en, alu_en, tx_d_valid} !== 5'b10000) begin
      bad++; $display("FAIL bad_cmd: err/wr/rd/alu/tx=%b want 10000",
                      {cmd_err, wr_en, rd_en, alu_en, tx_d_valid});
    end
    tick();
    total++;
    if (cmd_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle: cmd_err=%b want 0", cmd_err); end
  endtask

`ifdef RX_CMD_TIMEOUT_EN
  task automatic test_timeout();
    int w0, n;
    w0 = n_wr;
    send_byte(8'hAA);
    n = 0;
    while (!cmd_err && n < 40) begin tick(); n++; end
    total++;
    if (n !== 16) begin bad++; $display("FAIL timeout_cycle: err after %0d cycles want 16", n); end
    send_byte(8'h05);
    total++;
    if ({wr_en, cmd_err} !== 2'b00 || n_wr !== w0) begin
      bad++; $display("FAIL timeout_idle: wr_en=%b err=%b writes=%0d want 0/0/0",
                      wr_en, cmd_err, n_wr - w0);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int e0;
    e0 = n_err;
    send_byte(8'hAA);
    send_byte(8'h09);
    repeat (60) tick();
    send_byte(8'hE7);
    total++;
    if ({wr_en, addr, wr_data} !== {1'b1, 4'h9, 8'hE7} || n_err !== e0) begin
      bad++; $display("FAIL no_timeout: wr_en=%b addr=%h data=%h errs=%0d want 1/9/e7/0",
                      wr_en, addr, wr_data, n_err - e0);
    end
    tick();
  endtask
`endif

  task automatic gap();
    repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic test_random_frames();
    int base, tx_target, k, hold;
    logic [7:0] b, a, d, f, r;
    logic [15:0] v;
    base = obs.size();
    exp_q.delete();
    for (int fr = 0; fr < 40; fr++) begin
      tx_target = n_tx;
      case ($urandom_range(0, 4))
        0: begin
          a = 8'($urandom); d = 8'($urandom);
          send_byte(8'hAA); gap(); send_byte(a); gap(); send_byte(d);
          exp_q.push_back('{0, int'(a % 16), int'(d)});
        end
        1: begin
          a = 8'($urandom); r = 8'($urandom);
          send_byte(8'hBB); gap(); send_byte(a);
          exp_q.push_back('{1, int'(a % 16), 0});
          gap();
          if ($urandom_range(0, 1) == 1) begin send_byte(8'($urandom)); exp_q.push_back('{4, 0, 0}); end
          hold = $urandom_range(0, 6);
          tx_busy = (hold != 0);
          rd_data = r; rd_data_valid = 1'b1; tick(); rd_data_valid = 1'b0;
          repeat (hold) tick();
          tx_busy = 1'b0;
          exp_q.push_back('{3, 0, int'(r)});
          tx_target += 1;
        end
        2, 3: begin
          f = 8'($urandom); v = 16'($urandom);
          if (fr % 2 == 0) begin
            a = 8'($urandom); d = 8'($urandom);
            send_byte(8'hCC); gap(); send_byte(a); gap(); send_byte(d); gap();
            exp_q.push_back('{0, 0, int'(a)});
            exp_q.push_back('{0, 1, int'(d)});
          end else begin
            send_byte(8'hDD); gap();
          end
          send_byte(f);
          exp_q.push_back('{2, 0, int'(f % 16)});
          gap();
          if ($urandom_range(0, 2) == 0) begin send_byte(8'($urandom)); exp_q.push_back('{4, 0, 0}); end
          hold = $urandom_range(0, 6);
          tx_busy = (hold != 0);
          alu_out = v; alu_out_valid = 1'b1; tick(); alu_out_valid = 1'b0;
          repeat (hold) tick();
          tx_busy = 1'b0;
          exp_q.push_back('{3, 0, int'(v % 256)});
          exp_q.push_back('{3, 0, int'(v / 256)});
          tx_target += 2;
        end
        default: begin
          do b = 8'($urandom); while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
          send_byte(b);
          exp_q.push_back('{4, 0, 0});
        end
      endcase
      k = 0;
      while (n_tx < tx_target && k < 100) begin tick(); k++; end
      if (n_tx < tx_target) begin
        total++; bad++;
        $display("FAIL rand_tx_wait: frame %0d got %0d sends want %0d", fr, n_tx, tx_target);
      end
      tick();
    end
    total++;
    if (obs.size() - base !== exp_q.size()) begin
      bad++; $display("FAIL rand_count: events=%0d want %0d", obs.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs.size(); i++) begin
      total++;
      if (obs[base+i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_event %0d: got k=%0d a=%0d d=%0d want k=%0d a=%0d d=%0d", i,
                 obs[base+i].k, obs[base+i].a, obs[base+i].d, exp_q[i].k, exp_q[i].a, exp_q[i].d);
      end
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hCC);
    send_byte(8'h11);
    total++;
    if ({clk_gate_en, wr_en, addr, wr_data} !== {1'b1, 1'b1, 4'h0, 8'h11}) begin
      bad++; $display("FAIL mid_pre: gate=%b wr=%b addr=%h data=%h want 1/1/0/11",
                      clk_gate_en, wr_en, addr, wr_data);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (out_vec !== '0) begin bad++; $display("FAIL mid_reset: outputs=%h want 0", out_vec); end
    tick(); tick();
    rst = 1'b1;
    tick();
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h77);
    total++;
    if ({wr_en, addr, wr_data} !== {1'b1, 4'h2, 8'h77}) begin
      bad++; $display("FAIL post_reset_wr: wr_en=%b addr=%h data=%h want 1/2/77", wr_en, addr, wr_data);
    end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    rx_p_data = 8'h00; rx_d_valid = 1'b0;
    rd_data = 8'h00; rd_data_valid = 1'b0;
    alu_out = 16'h0000; alu_out_valid = 1'b0;
    tx_busy = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_alu();
    test_bad_cmd();
`ifdef RX_CMD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random_frames();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
